// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG block types and zigzag ordering
package jpeg_pkg;

  localparam int COEFF_WIDTH  = 11;
  localparam int BLOCK_COEFFS = 64;

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef coeff_t [7:0][7:0] block_t;

  // Raster index (row*8 + col) of each zigzag position.
  localparam logic [5:0] ZZ_ORDER [BLOCK_COEFFS] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

endpackage

// File: rtl/zz_bank_buffer.sv
// rtl/zz_bank_buffer.sv - two-bank 8x8 block store with write/read pointers
module zz_bank_buffer
  import jpeg_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0][7:0][WIDTH-1:0]  wr_block,
  input  logic                        release_bank,
  input  logic [5:0]                  rd_index,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_full,
  output logic                        busy,
  output logic                        accepted
);

  logic [7:0][7:0][WIDTH-1:0] mem [2];
  logic [1:0] full;
  logic       wp;
  logic       rp;

  // A write may land in a bank that is being drained on this same edge.
  assign accepted = wr_en && (!full[wp] || (release_bank && (rp == wp)));
  assign rd_full  = full[rp];
  assign rd_data  = mem[rp][rd_index[5:3]][rd_index[2:0]];
  assign busy     = |full;

  // Full flags and pointers; a capture is applied after a release so it wins on a shared bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
      wp   <= 1'b0;
      rp   <= 1'b0;
    end else begin
      if (release_bank) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
      end
      if (accepted) begin
        full[wp] <= 1'b1;
        wp       <= ~wp;
      end
    end
  end

  // Whole-block capture in a single cycle; contents need no reset.
  always_ff @(posedge clk) begin
    if (accepted) begin
      mem[wp] <= wr_block;
    end
  end

endmodule

// File: rtl/cr_zigzag_serializer.sv
// rtl/cr_zigzag_serializer.sv - Cr block capture and zigzag-order coefficient streamer
module cr_zigzag_serializer
  import jpeg_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [7:0][7:0][WIDTH-1:0]  Q,
  output logic signed [WIDTH-1:0]     coeff,
  output logic [5:0]                  coeff_index,
  output logic                        coeff_last,
  output logic                        coeff_valid,
  input  logic                        coeff_ready,
  output logic                        busy,
  output logic                        overflow
);

  logic [5:0]       k;
  logic [5:0]       rd_index;
  logic [WIDTH-1:0] rd_data;
  logic             rd_full;
  logic             accepted;
  logic             transfer;
  logic             last_beat;
  logic             release_bank;

  assign transfer     = coeff_valid && coeff_ready;
  assign last_beat    = (k == 6'(BLOCK_COEFFS - 1));
  assign release_bank = transfer && last_beat;
  assign rd_index     = ZZ_ORDER[k];

  zz_bank_buffer #(.WIDTH(WIDTH)) u_banks (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (enable),
    .wr_block     (Q),
    .release_bank (release_bank),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .rd_full      (rd_full),
    .busy         (busy),
    .accepted     (accepted)
  );

  // Outputs follow the read bank directly so reset clears them without waiting for a clock.
  always_comb begin
    coeff_valid = rd_full;
    coeff       = rd_full ? rd_data : '0;
    coeff_index = k;
    coeff_last  = last_beat;
  end

  // Beat counter wraps to 0 after the last coefficient; overflow is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= 6'd0;
      overflow <= 1'b0;
    end else begin
      if (transfer) begin
        k <= k + 6'd1;
      end
      if (enable && !accepted) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cr_zigzag_serializer.sv
// tb/tb_cr_zigzag_serializer.sv - directed self-checking bench for cr_zigzag_serializer
module tb_cr_zigzag_serializer;

  localparam int W = 11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   enable = 1'b0;
  logic                   coeff_ready = 1'b0;
  logic [7:0][7:0][W-1:0] q;
  logic signed [W-1:0]    coeff;
  logic [5:0]             coeff_index;
  logic                   coeff_last;
  logic                   coeff_valid;
  logic                   busy;
  logic                   overflow;

  int total = 0;
  int bad   = 0;
  int zz [64];

  cr_zigzag_serializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .Q           (q),
    .coeff       (coeff),
    .coeff_index (coeff_index),
    .coeff_last  (coeff_last),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Zigzag walk over anti-diagonals: even diagonals go up-right, odd go down-left.
  task automatic build_zz();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin zz[idx] = row * 8 + (s - row); idx++; end
      end else begin
        for (int row = lo; row <= hi; row++) begin zz[idx] = row * 8 + (s - row); idx++; end
      end
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        q[i][j] = W'(v);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        q[i][j] = W'(i * 8 + j);
  endtask

  task automatic pulse();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    fill(0);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (coeff_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", coeff_valid); end
    total++; if (coeff !== '0) begin bad++; $display("FAIL reset coeff: got %0d want 0", coeff); end
    total++; if (coeff_index !== 6'd0) begin bad++; $display("FAIL reset index: got %0d want 0", coeff_index); end
    total++; if (coeff_last !== 1'b0) begin bad++; $display("FAIL reset last: got %b want 0", coeff_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b want 0", overflow); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    fill_ramp();
    coeff_ready = 1'b1;
    pulse();
    for (int b = 0; b < 64; b++) begin
      total++;
      if (coeff_valid !== 1'b1 || coeff !== W'(zz[b]) || coeff_index !== 6'(b) || coeff_last !== (b == 63)) begin
        bad++;
        $display("FAIL ramp beat %0d: valid=%b coeff=%0d idx=%0d last=%b want coeff=%0d idx=%0d last=%b",
                 b, coeff_valid, coeff, coeff_index, coeff_last, zz[b], b, (b == 63));
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0 || coeff_valid !== 1'b0) begin bad++; $display("FAIL ramp idle: busy=%b valid=%b want 0 0", busy, coeff_valid); end
  endtask

  task automatic test_signed();
    int exp_v;
    fill(-1);
    q[0][0] = W'(-1024);
    q[7][7] = W'(1023);
    coeff_ready = 1'b1;
    pulse();
    for (int b = 0; b < 64; b++) begin
      exp_v = (b == 0) ? -1024 : (b == 63) ? 1023 : -1;
      total++;
      if (coeff_valid !== 1'b1 || coeff !== W'(exp_v) || coeff_index !== 6'(b)) begin
        bad++;
        $display("FAIL signed beat %0d: valid=%b coeff=%0d idx=%0d want coeff=%0d", b, coeff_valid, coeff, coeff_index, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int exp_v;
    fill(5);
    coeff_ready = 1'b1;
    pulse();
    for (int t = 0; t < 128; t++) begin
      exp_v = (t < 64) ? 5 : -7;
      total++;
      if (coeff_valid !== 1'b1 || coeff !== W'(exp_v) || coeff_index !== 6'(t % 64)) begin
        bad++;
        $display("FAIL b2b beat %0d: valid=%b coeff=%0d idx=%0d want coeff=%0d idx=%0d", t, coeff_valid, coeff, coeff_index, exp_v, t % 64);
      end
      if (t == 9) begin
        fill(-7);
        enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (overflow !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b end: overflow=%b busy=%b want 0 0", overflow, busy); end
  endtask

  task automatic test_backpressure();
    int kexp = 0;
    int held = 0;
    fill_ramp();
    coeff_ready = 1'b1;
    pulse();
    for (int cyc = 0; cyc < 80 && kexp < 64; cyc++) begin
      total++;
      if (coeff_valid !== 1'b1 || coeff_index !== 6'(kexp) || coeff !== W'(zz[kexp])) begin
        bad++;
        $display("FAIL bp cycle %0d: valid=%b coeff=%0d idx=%0d want coeff=%0d idx=%0d", cyc, coeff_valid, coeff, coeff_index, zz[kexp], kexp);
      end
      if (kexp == 20 && held < 3) begin
        coeff_ready = 1'b0;
        held++;
      end else begin
        coeff_ready = 1'b1;
        kexp++;
      end
      @(negedge clk);
    end
    total++; if (kexp != 64 || coeff_valid !== 1'b0) begin bad++; $display("FAIL bp end: beats=%0d valid=%b want 64 0", kexp, coeff_valid); end
  endtask

  task automatic test_overflow();
    int exp_v;
    coeff_ready = 1'b0;
    fill(1); pulse();
    fill(2); pulse();
    fill(3); pulse();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf flag: got %b want 1", overflow); end
    total++; if (coeff_valid !== 1'b1 || coeff !== W'(1) || coeff_index !== 6'd0) begin
      bad++; $display("FAIL ovf hold: valid=%b coeff=%0d idx=%0d want 1 1 0", coeff_valid, coeff, coeff_index);
    end
    coeff_ready = 1'b1;
    for (int t = 0; t < 128; t++) begin
      exp_v = (t < 64) ? 1 : 2;
      total++;
      if (coeff_valid !== 1'b1 || coeff !== W'(exp_v) || coeff_index !== 6'(t % 64)) begin
        bad++;
        $display("FAIL ovf beat %0d: valid=%b coeff=%0d idx=%0d want coeff=%0d", t, coeff_valid, coeff, coeff_index, exp_v);
      end
      @(negedge clk);
    end
    total++; if (coeff_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf end: valid=%b busy=%b overflow=%b want 0 0 1", coeff_valid, busy, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    fill_ramp();
    coeff_ready = 1'b1;
    pulse();
    for (int b = 0; b < 30; b++) @(negedge clk);
    total++; if (coeff_valid !== 1'b1 || coeff_index !== 6'd30 || coeff !== W'(zz[30])) begin
      bad++; $display("FAIL mid pre: valid=%b coeff=%0d idx=%0d want 1 %0d 30", coeff_valid, coeff, coeff_index, zz[30]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (coeff_valid !== 1'b0 || coeff !== '0 || coeff_index !== 6'd0 || coeff_last !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid async: valid=%b coeff=%0d idx=%0d last=%b busy=%b ovf=%b want all 0",
               coeff_valid, coeff, coeff_index, coeff_last, busy, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (coeff_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid after: valid=%b busy=%b want 0 0", coeff_valid, busy); end
  endtask

  initial begin
    build_zz();
    test_reset();
    test_ramp();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    test_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
